multicycle_main_fsm: RTL and testbench

- Main sequencing FSM for the multicycle ARMv4 core variant. It replaces the single-cycle Decoder's PCS/RegW/MemW/MemtoReg timing with a per-state control schedule over one shared ALU and a unified instruction/data memory.
- Outputs drive the datapath mux selects and the raw write strobes.
- Raw strobes RegW, MemW, Branch still pass through Conditional_Logic for Cond/flag gating. ALUOp feeds the existing ALU decoder.

---
 rtl/multicycle_main_fsm_pkg.sv | 47 ++++
 rtl/multicycle_main_fsm_if.sv | 32 +++
 rtl/multicycle_main_fsm_mc_output_decode.sv | 77 +++++++
 rtl/multicycle_main_fsm.sv | 75 +++++++
 tb/tb_multicycle_main_fsm.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/multicycle_main_fsm_pkg.sv
// State encoding and control-word constants for the multicycle main FSM.
// Optional macro MULTICYCLE_MEM_WAIT_EN is consumed by the top module.
package arm_mc_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [1:0] SRCA_RD1 = 2'b00;
    localparam logic [1:0] SRCA_PC  = 2'b01;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    typedef struct packed {
        logic       irwrite;
        logic       nextpc;
        logic       adrsrc;
        logic [1:0] alusrca;
        logic [1:0] alusrcb;
        logic       aluop;
        logic [1:0] resultsrc;
        logic       regw;
        logic       memw;
        logic       branch;
        logic       instr_done;
    } ctrl_t;

endpackage

// File: rtl/multicycle_main_fsm_if.sv
// Instruction-field inputs and datapath control outputs of the main FSM.
// master = FSM side, slave = datapath side.
interface multicycle_main_fsm_if;

    logic [1:0] Op;
    logic [5:0] Funct;
    logic       mem_ready;
    logic       IRWrite;
    logic       NextPC;
    logic       AdrSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       ALUOp;
    logic [1:0] ResultSrc;
    logic       RegW;
    logic       MemW;
    logic       Branch;
    logic       instr_done;

    modport master (
        input  Op, Funct, mem_ready,
        output IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ALUOp,
        output ResultSrc, RegW, MemW, Branch, instr_done
    );

    modport slave (
        output Op, Funct, mem_ready,
        input  IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ALUOp,
        input  ResultSrc, RegW, MemW, Branch, instr_done
    );

endinterface

// File: rtl/multicycle_main_fsm_mc_output_decode.sv
// Pure combinational state -> control-word mapping for the main FSM.
// During reset the FETCH selects are shown with every strobe cleared.
module mc_output_decode
    import arm_mc_pkg::*;
(
    input  logic       rst_i,
    input  state_t     state_i,
    input  logic       rdy_i,
    input  logic [1:0] op_i,
    output ctrl_t      ctrl_o
);

    state_t st;
    ctrl_t  c;

    always_comb begin
        c  = '0;
        st = rst_i ? FETCH : state_i;
        unique case (st)
            FETCH: begin
                c.alusrca   = SRCA_PC;
                c.alusrcb   = SRCB_FOUR;
                c.resultsrc = RES_ALU;
                c.irwrite   = rdy_i;
                c.nextpc    = rdy_i;
            end
            DECODE: begin
                c.alusrca    = SRCA_PC;
                c.alusrcb    = SRCB_FOUR;
                c.resultsrc  = RES_ALU;
                c.instr_done = (op_i == 2'b11);
            end
            MEMADR: c.alusrcb = SRCB_IMM;
            MEMREAD: c.adrsrc = 1'b1;
            MEMWB: begin
                c.resultsrc  = RES_DATA;
                c.regw       = 1'b1;
                c.instr_done = 1'b1;
            end
            MEMWRITE: begin
                c.adrsrc     = 1'b1;
                c.memw       = 1'b1;
                c.instr_done = rdy_i;
            end
            EXECR: begin
                c.alusrcb = SRCB_RD2;
                c.aluop   = 1'b1;
            end
            EXECI: begin
                c.alusrcb = SRCB_IMM;
                c.aluop   = 1'b1;
            end
            ALUWB: begin
                c.resultsrc  = RES_ALUOUT;
                c.regw       = 1'b1;
                c.instr_done = 1'b1;
            end
            BRANCH: begin
                c.alusrcb    = SRCB_IMM;
                c.resultsrc  = RES_ALU;
                c.branch     = 1'b1;
                c.instr_done = 1'b1;
            end
            default: c = '0;
        endcase
        if (rst_i) begin
            c.irwrite    = 1'b0;
            c.nextpc     = 1'b0;
            c.regw       = 1'b0;
            c.memw       = 1'b0;
            c.branch     = 1'b0;
            c.instr_done = 1'b0;
        end
        ctrl_o = c;
    end

endmodule

// File: rtl/multicycle_main_fsm.sv
// Multicycle ARMv4 main sequencing FSM: next-state logic and state register.
// Define MULTICYCLE_MEM_WAIT_EN to stall memory states on mem_ready.
module multicycle_main_fsm
    import arm_mc_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    multicycle_main_fsm_if.master bus
);

    state_t state_q, state_d;
    logic   rdy;
    ctrl_t  ctrl;

`ifdef MULTICYCLE_MEM_WAIT_EN
    assign rdy = bus.mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = bus.mem_ready;
    assign rdy = 1'b1;
`endif

    logic unused_funct;
    assign unused_funct = ^bus.Funct[4:1];

    always_ff @(posedge clk) begin
        if (rst) state_q <= FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH: if (rdy) state_d = DECODE;
            DECODE: begin
                unique case (bus.Op)
                    OP_MEM:  state_d = MEMADR;
                    OP_DP:   state_d = bus.Funct[5] ? EXECI : EXECR;
                    OP_BR:   state_d = BRANCH;
                    default: state_d = FETCH;
                endcase
            end
            MEMADR:   state_d = bus.Funct[0] ? MEMREAD : MEMWRITE;
            MEMREAD:  if (rdy) state_d = MEMWB;
            MEMWRITE: if (rdy) state_d = FETCH;
            EXECR,
            EXECI:    state_d = ALUWB;
            MEMWB,
            ALUWB,
            BRANCH:   state_d = FETCH;
            default:  state_d = FETCH;
        endcase
    end

    mc_output_decode u_dec (
        .rst_i   (rst),
        .state_i (state_q),
        .rdy_i   (rdy),
        .op_i    (bus.Op),
        .ctrl_o  (ctrl)
    );

    assign bus.IRWrite    = ctrl.irwrite;
    assign bus.NextPC     = ctrl.nextpc;
    assign bus.AdrSrc     = ctrl.adrsrc;
    assign bus.ALUSrcA    = ctrl.alusrca;
    assign bus.ALUSrcB    = ctrl.alusrcb;
    assign bus.ALUOp      = ctrl.aluop;
    assign bus.ResultSrc  = ctrl.resultsrc;
    assign bus.RegW       = ctrl.regw;
    assign bus.MemW       = ctrl.memw;
    assign bus.Branch     = ctrl.branch;
    assign bus.instr_done = ctrl.instr_done;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Directed bench for multicycle_main_fsm; control word is
// {IRW,NPC,Adr,SrcA,SrcB,ALUOp,Res,RegW,MemW,Br,done}.
module tb_multicycle_main_fsm;

    logic clk = 1'b0;
    logic rst;
    int   n_run  = 0;
    int   n_fail = 0;

    multicycle_main_fsm_if bus ();

    multicycle_main_fsm dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [13:0] cw;
    assign cw = {bus.IRWrite, bus.NextPC, bus.AdrSrc, bus.ALUSrcA,
                 bus.ALUSrcB, bus.ALUOp, bus.ResultSrc, bus.RegW,
                 bus.MemW, bus.Branch, bus.instr_done};

    localparam logic [13:0] W_FETCH  = 14'b1_1_0_01_10_0_10_0_0_0_0;
    localparam logic [13:0] W_FWAIT  = 14'b0_0_0_01_10_0_10_0_0_0_0;
    localparam logic [13:0] W_RST    = 14'b0_0_0_01_10_0_10_0_0_0_0;
    localparam logic [13:0] W_DEC    = 14'b0_0_0_01_10_0_10_0_0_0_0;
    localparam logic [13:0] W_DECU   = 14'b0_0_0_01_10_0_10_0_0_0_1;
    localparam logic [13:0] W_MADR   = 14'b0_0_0_00_01_0_00_0_0_0_0;
    localparam logic [13:0] W_MRD    = 14'b0_0_1_00_00_0_00_0_0_0_0;
    localparam logic [13:0] W_MWB    = 14'b0_0_0_00_00_0_01_1_0_0_1;
    localparam logic [13:0] W_MWR    = 14'b0_0_1_00_00_0_00_0_1_0_1;
    localparam logic [13:0] W_MWRW   = 14'b0_0_1_00_00_0_00_0_1_0_0;
    localparam logic [13:0] W_EXR    = 14'b0_0_0_00_00_1_00_0_0_0_0;
    localparam logic [13:0] W_EXI    = 14'b0_0_0_00_01_1_00_0_0_0_0;
    localparam logic [13:0] W_AWB    = 14'b0_0_0_00_00_0_00_1_0_0_1;
    localparam logic [13:0] W_BR     = 14'b0_0_0_00_01_0_10_0_0_1_1;

    task automatic check(input string tag, input logic [13:0] got,
                         input logic [13:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b want %b", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        bus.mem_ready = 1'b1;
        bus.Op        = 2'b01;
        bus.Funct     = 6'b011001;
        tick;
        tick;
        check("reset", cw, W_RST);
        rst = 1'b0;
        #1;
        check("fetch0", cw, W_FETCH);

        // LDR imm, 5 cycles
        tick; check("ldr_dec", cw, W_DEC);
        tick; check("ldr_madr", cw, W_MADR);
        tick; check("ldr_mrd", cw, W_MRD);
        tick; check("ldr_mwb", cw, W_MWB);
        tick; check("ldr_fetch", cw, W_FETCH);

        // reset while in MEMREAD
        tick; check("rm_dec", cw, W_DEC);
        tick; check("rm_madr", cw, W_MADR);
        tick; check("rm_mrd", cw, W_MRD);
        rst = 1'b1;
        #1;
        check("rm_rsthi", cw, W_RST);
        tick;
        rst = 1'b0;
        #1;
        check("rm_fetch", cw, W_FETCH);

        // STR
        bus.Funct = 6'b011000;
        tick; check("str_dec", cw, W_DEC);
        tick; check("str_madr", cw, W_MADR);
        tick;
`ifdef MULTICYCLE_MEM_WAIT_EN
        bus.mem_ready = 1'b0;
        #1;
        check("str_w0", cw, W_MWRW);
        tick; check("str_w1", cw, W_MWRW);
        tick; check("str_w2", cw, W_MWRW);
        tick;
        bus.mem_ready = 1'b1;
        #1;
        check("str_w3", cw, W_MWR);
        tick; check("str_fetch", cw, W_FETCH);
        bus.mem_ready = 1'b0;
        #1;
        check("fetch_hold", cw, W_FWAIT);
        tick; check("fetch_hold2", cw, W_FWAIT);
        bus.mem_ready = 1'b1;
        #1;
        check("fetch_go", cw, W_FETCH);
`else
        bus.mem_ready = 1'b0;
        #1;
        check("str_mwr", cw, W_MWR);
        tick; check("str_fetch", cw, W_FETCH);
        bus.mem_ready = 1'b1;
`endif

        // ADD imm, 4 cycles
        bus.Op    = 2'b00;
        bus.Funct = 6'b101000;
        tick; check("addi_dec", cw, W_DEC);
        tick; check("addi_exi", cw, W_EXI);
        tick; check("addi_awb", cw, W_AWB);
        tick; check("addi_fetch", cw, W_FETCH);

        // ADD reg
        bus.Funct = 6'b001000;
        tick; check("addr_dec", cw, W_DEC);
        tick; check("addr_exr", cw, W_EXR);
        tick; check("addr_awb", cw, W_AWB);
        tick; check("addr_fetch", cw, W_FETCH);

        // B, 3 cycles
        bus.Op = 2'b10;
        tick; check("b_dec", cw, W_DEC);
        tick; check("b_br", cw, W_BR);
        tick; check("b_fetch", cw, W_FETCH);

        // undefined op, 2 cycles
        bus.Op = 2'b11;
        tick; check("und_dec", cw, W_DECU);
        tick; check("und_fetch", cw, W_FETCH);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
